// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, arbiter state encoding, counter sizing.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Bits needed to count 0..maxv inclusive; at least one bit so a
  // disabled limit (maxv == 0) still yields a legal vector.
  function automatic int cnt_w(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping.
// Purely combinational so it can be dropped into other bus arbiters.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     off;
  logic [W:0]     sum;

  // Rotate so bit 0 is the requester right after 'last', then priority-encode.
  always_comb begin
    any = |req;
    dbl = {req, req} >> last;
    rot = dbl[N:1];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (W+1)'(i);
    end
    sum = {1'b0, last} + off + (W+1)'(1);
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among NumReq
// byte-stream requesters. The winner is muxed straight onto tx_* while
// locked; a grant ends on a last byte, the burst limit, or idle timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq      = 4,
  parameter int MaxBurst    = 16,
  parameter int IdleTimeout = 64,
  localparam int GW         = $clog2(NumReq)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumReq-1:0][DATA_W-1:0]  req_data,
  input  logic [NumReq-1:0]              req_valid,
  input  logic [NumReq-1:0]              req_last,
  output logic [NumReq-1:0]              req_ready,
  output logic [DATA_W-1:0]              tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [GW-1:0]                  grant_id,
  output logic                           busy
);

  localparam int BW = cnt_w(MaxBurst);
  localparam int IW = cnt_w(IdleTimeout);

  arb_state_t  state;
  logic [GW-1:0] last_grant;
  logic [BW-1:0] burst_cnt;
  logic [IW-1:0] idle_cnt;

  logic          pick_any;
  logic [GW-1:0] pick_idx;
  logic          locked;
  logic          g_valid;
  logic          xfer;
  logic          rel_last;
  logic          rel_burst;
  logic          rel_idle;
  logic          release_now;

  rr_pick #(.N(NumReq), .W(GW)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Winner passthrough and release conditions for the current cycle.
  always_comb begin
    locked    = (state == ARB_LOCKED);
    g_valid   = req_valid[grant_id];
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (locked) begin
      tx_valid            = g_valid;
      tx_data             = req_data[grant_id];
      req_ready[grant_id] = tx_ready;
    end
    xfer      = tx_valid && tx_ready;
    rel_last  = xfer && req_last[grant_id];
    rel_burst = xfer && (MaxBurst != 0) && (int'(burst_cnt) + 1 == MaxBurst);
    // Only counts while the owner is not presenting, so never drops a held byte.
    rel_idle  = locked && !g_valid && (IdleTimeout != 0) &&
                (int'(idle_cnt) + 1 == IdleTimeout);
    release_now = rel_last || rel_burst || rel_idle;
  end

  // Grant FSM with burst/idle bookkeeping; counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_grant <= GW'(NumReq - 1);
      burst_cnt  <= '0;
      idle_cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state     <= ARB_LOCKED;
            busy      <= 1'b1;
            grant_id  <= pick_idx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        ARB_LOCKED: begin
          if (xfer && burst_cnt != '1) burst_cnt <= burst_cnt + 1'b1;
          if (g_valid)                 idle_cnt  <= '0;
          else if (idle_cnt != '1)     idle_cnt  <= idle_cnt + 1'b1;
          if (release_now) begin
            state      <= ARB_IDLE;
            busy       <= 1'b0;
            last_grant <= grant_id;
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
